ife_redundant_dispatch_ctrl: RTL

- Parametrised successor to the IFE top-level dispatch/commit path.
- Accepts one instruction block at a time and dispatches it to REDUNDANCY idle cores, chosen from NUM_CORES.
- Collects a per-core result signature and commits the block only if all signatures match.
- On mismatch, result timeout, core starvation or parallel mode disabled, it redirects the block to the serial fallback path over a valid/ready handshake. It also keeps saturating commit and fallback statistics.

---
 rtl/ife_redundant_dispatch_ctrl_if.sv | 47 ++++
 rtl/ife_redundant_dispatch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ife_redundant_dispatch_ctrl_if.sv
// Handshake and bus bundle for the redundant dispatch controller.
// The slave modport is the controller's view and the master modport is the environment's view.
interface ife_redundant_dispatch_ctrl_if #(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int NUM_CORES      = 4,
  parameter int SIG_WIDTH      = 64,
  parameter int CNT_WIDTH      = 16
);
  logic                              par_enable;
  logic                              in_valid;
  logic                              in_ready;
  logic [BLOCK_ID_WIDTH-1:0]         in_block_id;
  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] in_block_data;
  logic [NUM_CORES-1:0]              core_busy;
  logic [NUM_CORES-1:0]              disp_valid;
  logic [BLOCK_ID_WIDTH-1:0]         disp_block_id;
  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] disp_block_data;
  logic [NUM_CORES-1:0]              res_valid;
  logic [NUM_CORES*SIG_WIDTH-1:0]    res_sig;
  logic                              commit_valid;
  logic [BLOCK_ID_WIDTH-1:0]         commit_block_id;
  logic                              serial_valid;
  logic                              serial_ready;
  logic [BLOCK_ID_WIDTH-1:0]         serial_block_id;
  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] serial_block_data;
  logic [1:0]                        serial_reason;
  logic [CNT_WIDTH-1:0]              cnt_commit;
  logic [CNT_WIDTH-1:0]              cnt_fallback;

  modport slave (
    input  par_enable, in_valid, in_block_id, in_block_data, core_busy,
           res_valid, res_sig, serial_ready,
    output in_ready, disp_valid, disp_block_id, disp_block_data,
           commit_valid, commit_block_id, serial_valid, serial_block_id,
           serial_block_data, serial_reason, cnt_commit, cnt_fallback
  );

  modport master (
    output par_enable, in_valid, in_block_id, in_block_data, core_busy,
           res_valid, res_sig, serial_ready,
    input  in_ready, disp_valid, disp_block_id, disp_block_data,
           commit_valid, commit_block_id, serial_valid, serial_block_id,
           serial_block_data, serial_reason, cnt_commit, cnt_fallback
  );
endinterface

// File: rtl/ife_redundant_dispatch_ctrl.sv
// Redundant dispatch/commit controller: one block at a time is sent to REDUNDANCY
// idle cores, committed when all returned signatures agree, and otherwise handed to
// the serial fallback path with a reason code. Commit/fallback counts saturate.
module ife_redundant_dispatch_ctrl #(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int NUM_CORES      = 4,
  parameter int REDUNDANCY     = 2,
  parameter int SIG_WIDTH      = 64,
  parameter int ALLOC_LIMIT    = 16,
  parameter int TIMEOUT        = 64,
  parameter int CNT_WIDTH      = 16
) (
  input logic clk,
  input logic rst,
  ife_redundant_dispatch_ctrl_if.slave bus
);
  localparam int DATA_W = BLOCK_SIZE * INSTR_WIDTH;
  localparam int ATW    = $clog2(ALLOC_LIMIT + 1);
  localparam int TTW    = $clog2(TIMEOUT + 1);
  localparam logic [ATW-1:0] ALLOC_END = ATW'(ALLOC_LIMIT);
  localparam logic [TTW-1:0] WAIT_END  = TTW'(TIMEOUT);

  localparam logic [1:0] RSN_BYPASS   = 2'd0;
  localparam logic [1:0] RSN_NOCORES  = 2'd1;
  localparam logic [1:0] RSN_TIMEOUT  = 2'd2;
  localparam logic [1:0] RSN_MISMATCH = 2'd3;

  typedef enum logic [2:0] {IDLE, ALLOC, WAIT, COMPARE, SERIAL} state_t;

  state_t                    state;
  logic                      in_ready_q;
  logic [BLOCK_ID_WIDTH-1:0] id_q;
  logic [DATA_W-1:0]         data_q;
  logic [NUM_CORES-1:0]      sel_mask;
  logic [NUM_CORES-1:0]      seen_mask;
  logic [NUM_CORES-1:0]      disp_valid_q;
  logic [ATW-1:0]            alloc_tmr;
  logic [TTW-1:0]            res_tmr;
  logic [SIG_WIDTH-1:0]      sig_q [NUM_CORES];
  logic                      commit_valid_q;
  logic [BLOCK_ID_WIDTH-1:0] commit_id_q;
  logic                      serial_valid_q;
  logic [1:0]                reason_q;
  logic [CNT_WIDTH-1:0]      cnt_commit_q;
  logic [CNT_WIDTH-1:0]      cnt_fallback_q;

  logic                      enough_idle;
  logic [NUM_CORES-1:0]      pick_mask;
  logic [NUM_CORES-1:0]      cap_mask;
  logic [NUM_CORES-1:0]      seen_next;
  logic                      sigs_equal;
  logic [ATW-1:0]            alloc_tmr_inc;
  logic [TTW-1:0]            res_tmr_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign alloc_tmr_inc = alloc_tmr + ATW'(1);
  assign res_tmr_inc   = res_tmr + TTW'(1);
  assign cap_mask      = bus.res_valid & sel_mask & ~seen_mask;
  assign seen_next     = seen_mask | cap_mask;

  // Count idle cores and pick the lowest-index REDUNDANCY of them.
  always_comb begin
    int idle_cnt;
    int picked;
    idle_cnt  = 0;
    picked    = 0;
    pick_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!bus.core_busy[i]) begin
        idle_cnt = idle_cnt + 1;
        if (picked < REDUNDANCY) begin
          pick_mask[i] = 1'b1;
          picked       = picked + 1;
        end
      end
    end
    enough_idle = (idle_cnt >= REDUNDANCY);
  end

  // All captured signatures of the selected cores agree with the first selected one.
  always_comb begin
    logic [SIG_WIDTH-1:0] ref_sig;
    logic                 found;
    ref_sig    = '0;
    found      = 1'b0;
    sigs_equal = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (sel_mask[i]) begin
        if (!found) begin
          ref_sig = sig_q[i];
          found   = 1'b1;
        end else if (sig_q[i] != ref_sig) begin
          sigs_equal = 1'b0;
        end
      end
    end
  end

  // Control FSM with registered outputs, latches, timers and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      in_ready_q     <= 1'b0;
      id_q           <= '0;
      data_q         <= '0;
      sel_mask       <= '0;
      seen_mask      <= '0;
      disp_valid_q   <= '0;
      alloc_tmr      <= '0;
      res_tmr        <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      serial_valid_q <= 1'b0;
      reason_q       <= '0;
      cnt_commit_q   <= '0;
      cnt_fallback_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) sig_q[i] <= '0;
    end else begin
      disp_valid_q   <= '0;
      commit_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            id_q       <= bus.in_block_id;
            data_q     <= bus.in_block_data;
            in_ready_q <= 1'b0;
            if (bus.par_enable) begin
              alloc_tmr <= '0;
              state     <= ALLOC;
            end else begin
              serial_valid_q <= 1'b1;
              reason_q       <= RSN_BYPASS;
              state          <= SERIAL;
            end
          end
        end
        ALLOC: begin
          if (enough_idle) begin
            sel_mask     <= pick_mask;
            disp_valid_q <= pick_mask;
            seen_mask    <= '0;
            res_tmr      <= '0;
            state        <= WAIT;
          end else if (alloc_tmr_inc == ALLOC_END) begin
            serial_valid_q <= 1'b1;
            reason_q       <= RSN_NOCORES;
            state          <= SERIAL;
          end else begin
            alloc_tmr <= alloc_tmr_inc;
          end
        end
        WAIT: begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (cap_mask[i]) sig_q[i] <= bus.res_sig[i*SIG_WIDTH +: SIG_WIDTH];
          end
          seen_mask <= seen_next;
          if (seen_next == sel_mask) begin
            state <= COMPARE;
          end else if (res_tmr_inc == WAIT_END) begin
            serial_valid_q <= 1'b1;
            reason_q       <= RSN_TIMEOUT;
            state          <= SERIAL;
          end else begin
            res_tmr <= res_tmr_inc;
          end
        end
        COMPARE: begin
          if (sigs_equal) begin
            commit_valid_q <= 1'b1;
            commit_id_q    <= id_q;
            cnt_commit_q   <= sat_inc(cnt_commit_q);
            in_ready_q     <= 1'b1;
            state          <= IDLE;
          end else begin
            serial_valid_q <= 1'b1;
            reason_q       <= RSN_MISMATCH;
            state          <= SERIAL;
          end
        end
        SERIAL: begin
          if (bus.serial_ready) begin
            serial_valid_q <= 1'b0;
            cnt_fallback_q <= sat_inc(cnt_fallback_q);
            in_ready_q     <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.disp_valid        = disp_valid_q;
  assign bus.disp_block_id     = id_q;
  assign bus.disp_block_data   = data_q;
  assign bus.commit_valid      = commit_valid_q;
  assign bus.commit_block_id   = commit_id_q;
  assign bus.serial_valid      = serial_valid_q;
  assign bus.serial_block_id   = id_q;
  assign bus.serial_block_data = data_q;
  assign bus.serial_reason     = reason_q;
  assign bus.cnt_commit        = cnt_commit_q;
  assign bus.cnt_fallback      = cnt_fallback_q;
endmodule
